// File: rtl/ped_pkg.sv
// Shared definitions for the pedestrian crossing controller.
// Holds the FSM state encoding, the timer/counter width and the
// vehicle-lamp one-hot check used by the crossing controller.
package ped_pkg;

    localparam int unsigned TMR_W = 4;

    localparam logic [1:0] IDLE     = 2'b00;
    localparam logic [1:0] WAIT_RED = 2'b01;
    localparam logic [1:0] WALK     = 2'b10;
    localparam logic [1:0] CLEAR    = 2'b11;

    // True when exactly one of the three vehicle lamps is lit
    function automatic logic lights_ok(input logic red, input logic green, input logic yellow);
        return (red ^ green ^ yellow) & ~(red & green & yellow);
    endfunction

endpackage

// File: rtl/ped_btn_debounce.sv
// Pedestrian button conditioning: 2-FF synchroniser, saturating debounce
// counter and a one-cycle pulse on the rising edge of the debounced level.
// Ports:
//   clk, reset    - clock, asynchronous active-high reset
//   i_btn         - raw asynchronous push-button
//   o_press_c     - combinational one-cycle pulse when a press is accepted
module ped_btn_debounce
    import ped_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_press_c
);

    logic             r_sync1;
    logic             r_sync2;
    logic [TMR_W-1:0] r_cnt;
    logic             r_db_d;
    logic             w_db;

    assign w_db      = (r_cnt == TMR_W'(DEBOUNCE_CYC));
    assign o_press_c = w_db & ~r_db_d;

    // Synchroniser, debounce counter (holds at threshold) and edge history
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_cnt   <= '0;
            r_db_d  <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            if (!r_sync2) begin
                r_cnt <= '0;
            end else if (!w_db) begin
                r_cnt <= r_cnt + TMR_W'(1);
            end
            r_db_d <= w_db;
        end
    end

endmodule

// File: rtl/ped_crossing_ctrl.sv
// Pedestrian crossing controller. Watches the vehicle lamps, latches a
// debounced button request and grants WALK at the start of a vehicle-red
// phase, followed by a flashing DON'T-WALK clearance with countdown.
// Any non-one-hot vehicle lamp pattern, or red ending early, forces the
// safe state (solid DON'T-WALK).
// Ports:
//   clk, reset                     - clock, asynchronous active-high reset
//   veh_red, veh_green, veh_yellow - vehicle lamps from the traffic controller
//   ped_btn                        - raw pedestrian push-button
//   walk, dont_walk, flash         - pedestrian lamps (registered)
//   countdown                      - remaining clearance cycles, 0 otherwise
//   req_pending                    - accepted request awaiting service
//   fault                          - vehicle lamps were not one-hot last cycle
//   chirp                          - audible cue, only when PED_CHIRP_EN is defined
// Build option: define PED_CHIRP_EN to add the chirp output.
module ped_crossing_ctrl
    import ped_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = 4,
    parameter int unsigned WALK_CYC     = 6,
    parameter int unsigned CLEAR_CYC    = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             veh_red,
    input  logic             veh_green,
    input  logic             veh_yellow,
    input  logic             ped_btn,
    output logic             walk,
    output logic             dont_walk,
    output logic             flash,
    output logic [TMR_W-1:0] countdown,
    output logic             req_pending,
    output logic             fault
`ifdef PED_CHIRP_EN
    ,
    output logic             chirp
`endif
);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [TMR_W-1:0] r_timer;
    logic [TMR_W-1:0] w_timer_nxt;
    logic             r_red_d;
    logic             w_lights_ok;
    logic             w_red_start;
    logic             w_abort;
    logic             w_press;
    logic             w_serve;
    logic             w_walk_nxt;
    logic             w_dont_walk_nxt;
    logic             w_flash_nxt;
    logic [TMR_W-1:0] w_countdown_nxt;
`ifdef PED_CHIRP_EN
    logic             w_chirp_nxt;
`endif

    ped_btn_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_btn (
        .clk       (clk),
        .reset     (reset),
        .i_btn     (ped_btn),
        .o_press_c (w_press)
    );

    assign w_lights_ok = lights_ok(veh_red, veh_green, veh_yellow);
    assign w_red_start = veh_red & ~r_red_d & w_lights_ok;
    assign w_abort     = ~veh_red | ~w_lights_ok;
    assign w_serve     = (r_state == WAIT_RED) && (w_state_nxt == WALK);

    // State register with phase timer and red-edge history
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_timer <= '0;
            r_red_d <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_red_d <= veh_red;
        end
    end

    // Next-state and timer logic; bad lamp patterns always fall back to IDLE
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        case (r_state)
            IDLE: begin
                if (req_pending && w_lights_ok) begin
                    w_state_nxt = WAIT_RED;
                end
            end
            WAIT_RED: begin
                if (!w_lights_ok) begin
                    w_state_nxt = IDLE;
                end else if (w_red_start) begin
                    w_state_nxt = WALK;
                    w_timer_nxt = TMR_W'(WALK_CYC - 1);
                end
            end
            WALK: begin
                if (w_abort) begin
                    w_state_nxt = IDLE;
                    w_timer_nxt = '0;
                end else if (r_timer == '0) begin
                    w_state_nxt = CLEAR;
                    w_timer_nxt = TMR_W'(CLEAR_CYC - 1);
                end else begin
                    w_timer_nxt = r_timer - TMR_W'(1);
                end
            end
            CLEAR: begin
                if (w_abort || (r_timer == '0)) begin
                    w_state_nxt = IDLE;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer - TMR_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_timer_nxt = '0;
            end
        endcase
    end

    // Output decode from the upcoming state so lamps change with the state
    always_comb begin
        w_walk_nxt      = 1'b0;
        w_dont_walk_nxt = 1'b1;
        w_flash_nxt     = 1'b0;
        w_countdown_nxt = '0;
`ifdef PED_CHIRP_EN
        w_chirp_nxt     = 1'b0;
`endif
        case (w_state_nxt)
            WALK: begin
                w_walk_nxt      = 1'b1;
                w_dont_walk_nxt = 1'b0;
`ifdef PED_CHIRP_EN
                w_chirp_nxt     = ~chirp;
`endif
            end
            CLEAR: begin
                w_flash_nxt     = 1'b1;
                w_countdown_nxt = w_timer_nxt;
                // Solid on entry, then alternate each cycle
                w_dont_walk_nxt = (r_state == CLEAR) ? ~dont_walk : 1'b1;
`ifdef PED_CHIRP_EN
                // dont_walk alternates in CLEAR, so gating on it halves the rate
                w_chirp_nxt     = ((r_state == CLEAR) && dont_walk) ? ~chirp : chirp;
`endif
            end
            default: begin
                w_dont_walk_nxt = 1'b1;
            end
        endcase
    end

    // Output and request registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            walk        <= 1'b0;
            dont_walk   <= 1'b1;
            flash       <= 1'b0;
            countdown   <= '0;
            req_pending <= 1'b0;
            fault       <= 1'b0;
`ifdef PED_CHIRP_EN
            chirp       <= 1'b0;
`endif
        end else begin
            walk      <= w_walk_nxt;
            dont_walk <= w_dont_walk_nxt;
            flash     <= w_flash_nxt;
            countdown <= w_countdown_nxt;
            fault     <= ~w_lights_ok;
`ifdef PED_CHIRP_EN
            chirp     <= w_chirp_nxt;
`endif
            // Serving wins over a coincident press; that press is absorbed
            if (w_serve) begin
                req_pending <= 1'b0;
            end else if (w_press) begin
                req_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Self-checking bench for ped_crossing_ctrl: directed scenarios plus a
// randomized run, all compared against a phase-index reference model.
module tb_ped_crossing_ctrl;

    localparam int unsigned D      = 4;
    localparam int unsigned W      = 6;
    localparam int unsigned C      = 5;
    localparam int          TL_PER = 30;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       veh_red = 1'b0;
    logic       veh_green = 1'b0;
    logic       veh_yellow = 1'b0;
    logic       ped_btn = 1'b0;
    logic       walk;
    logic       dont_walk;
    logic       flash;
    logic [3:0] countdown;
    logic       req_pending;
    logic       fault;
`ifdef PED_CHIRP_EN
    logic       chirp;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int tl_t = 0;

    ped_crossing_ctrl #(
        .DEBOUNCE_CYC (D),
        .WALK_CYC     (W),
        .CLEAR_CYC    (C)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .veh_red     (veh_red),
        .veh_green   (veh_green),
        .veh_yellow  (veh_yellow),
        .ped_btn     (ped_btn),
        .walk        (walk),
        .dont_walk   (dont_walk),
        .flash       (flash),
        .countdown   (countdown),
        .req_pending (req_pending),
        .fault       (fault)
`ifdef PED_CHIRP_EN
        ,
        .chirp       (chirp)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // m_k is the index of the current cycle inside the WALK+CLEAR window, -1 when inactive.
    int   m_k = -1;
    logic m_wait = 1'b0;
    logic m_pend = 1'b0;
    logic m_red_d = 1'b0;
    logic m_fault = 1'b0;
    int   rh0 = 0, rh1 = 0, rh2 = 0;   // raw-button run lengths 1, 2, 3 edges ago

    always @(posedge clk or posedge reset) begin
        logic lok, rs, started, acc;
        if (reset) begin
            m_k = -1; m_wait = 1'b0; m_pend = 1'b0; m_red_d = 1'b0; m_fault = 1'b0;
            rh0 = 0; rh1 = 0; rh2 = 0;
        end else begin
            lok     = ($countones({veh_red, veh_green, veh_yellow}) == 1);
            rs      = veh_red && !m_red_d && lok;
            started = 1'b0;
            // a press is accepted when the run seen 3 edges ago just reached D
            acc     = (rh2 == int'(D));
            if (m_k >= 0) begin
                if (!veh_red || !lok) m_k = -1;
                else begin
                    m_k = m_k + 1;
                    if (m_k == int'(W + C)) m_k = -1;
                end
            end else if (m_wait) begin
                if (!lok) m_wait = 1'b0;
                else if (rs) begin
                    m_k = 0; m_wait = 1'b0; started = 1'b1;
                end
            end else if (m_pend && lok) begin
                m_wait = 1'b1;
            end
            if (started) m_pend = 1'b0;
            else if (acc) m_pend = 1'b1;
            rh2 = rh1;
            rh1 = rh0;
            rh0 = ped_btn ? ((rh0 < 1000) ? rh0 + 1 : rh0) : 0;
            m_red_d = veh_red;
            m_fault = !lok;
        end
    end

    logic       e_walk, e_flash, e_dw;
    logic [3:0] e_cd;
    logic [8:0] m_exp;
    assign e_walk  = (m_k >= 0) && (m_k < int'(W));
    assign e_flash = (m_k >= int'(W));
    assign e_cd    = e_flash ? 4'(int'(W + C) - 1 - m_k) : 4'd0;
    assign e_dw    = !e_walk && !(e_flash && (((m_k - int'(W)) % 2) == 1));
    assign m_exp   = {e_walk, e_dw, e_flash, e_cd, m_pend, m_fault};

    // ---------------- stimulus helpers ----------------
    function automatic logic [2:0] tl_rgy(input int t);
        if (t < 11) return 3'b010;
        if (t < 14) return 3'b001;
        return 3'b100;
    endfunction

    // Apply one cycle of inputs at the falling edge, return at the next falling edge
    task automatic drive(input logic b, input logic ovr, input logic [2:0] rgy);
        {veh_red, veh_green, veh_yellow} = ovr ? rgy : tl_rgy(tl_t);
        ped_btn = b;
        tl_t = (tl_t + 1) % TL_PER;
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [8:0] obs;
        logic [8:0] rst_vec;
        rst_vec = {1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0};
        tl_t = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 3'b000);
            obs = {walk, dont_walk, flash, countdown, req_pending, fault};
            n_checks++;
            if (obs !== rst_vec) begin
                n_errors++;
                $display("FAIL reset_hold i=%0d: got %b, expected %b", i, obs, rst_vec);
            end
        end
        reset = 1'b0;
        tl_t = 0;
        for (int i = 0; i < TL_PER; i++) begin
            drive(1'b0, 1'b0, 3'b000);
            obs = {walk, dont_walk, flash, countdown, req_pending, fault};
            n_checks++;
            if (obs !== rst_vec || obs !== m_exp) begin
                n_errors++;
                $display("FAIL reset_idle i=%0d: got %b, expected %b", i, obs, rst_vec);
            end
        end
    endtask

    task automatic test_walk_cycle();
        logic [8:0] obs;
        int first_req = 0, n_walk = 0, n_fl = 0;
        logic [3:0] cd [5];
        logic       dw [5];
`ifdef PED_CHIRP_EN
        logic prev_walk = 1'b0, prev_chirp = 1'b0;
`endif
        for (int i = 0; i < TL_PER; i++) begin
            drive(i < 8, 1'b0, 3'b000);
            obs = {walk, dont_walk, flash, countdown, req_pending, fault};
            n_checks++;
            if (obs !== m_exp) begin
                n_errors++;
                $display("FAIL walk_cycle i=%0d: got %b, expected %b", i, obs, m_exp);
            end
            if (req_pending && first_req == 0) first_req = i + 1;
            if (walk) n_walk++;
            if (flash) begin
                if (n_fl < 5) begin cd[n_fl] = countdown; dw[n_fl] = dont_walk; end
                n_fl++;
            end
`ifdef PED_CHIRP_EN
            if (walk && prev_walk) begin
                n_checks++;
                if (chirp === prev_chirp) begin
                    n_errors++;
                    $display("FAIL chirp_toggle i=%0d: got %b, expected %b", i, chirp, ~prev_chirp);
                end
            end
            prev_walk = walk; prev_chirp = chirp;
`endif
        end
        n_checks++;
        if (first_req == 0 || first_req > 7) begin
            n_errors++;
            $display("FAIL req_latency: got %0d cycles, expected 1..7", first_req);
        end
        n_checks++;
        if (n_walk != int'(W)) begin
            n_errors++;
            $display("FAIL walk_len: got %0d, expected %0d", n_walk, W);
        end
        n_checks++;
        if (n_fl != int'(C)) begin
            n_errors++;
            $display("FAIL clear_len: got %0d, expected %0d", n_fl, C);
        end
        for (int j = 0; j < 5; j++) begin
            n_checks++;
            if (cd[j] !== 4'(int'(C) - 1 - j) || dw[j] !== ((j % 2) == 0)) begin
                n_errors++;
                $display("FAIL clear_seq j=%0d: got cd=%0d dw=%b, expected cd=%0d dw=%b",
                         j, cd[j], dw[j], int'(C) - 1 - j, ((j % 2) == 0));
            end
        end
        n_checks++;
        if (req_pending !== 1'b0) begin
            n_errors++;
            $display("FAIL req_cleared: got %b, expected 0", req_pending);
        end
    endtask

    task automatic test_glitch();
        logic [8:0] obs;
        logic seen = 1'b0;
        for (int i = 0; i < TL_PER; i++) begin
            drive(i >= 2 && i < 4, 1'b0, 3'b000);
            obs = {walk, dont_walk, flash, countdown, req_pending, fault};
            n_checks++;
            if (obs !== m_exp) begin
                n_errors++;
                $display("FAIL glitch i=%0d: got %b, expected %b", i, obs, m_exp);
            end
            if (req_pending || walk) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_errors++;
            $display("FAIL glitch_ignored: got request=%b, expected 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] obs;
        int n_walk = 0, n_starts = 0;
        logic prev_walk = 1'b0, req_in_cycle = 1'b0;
        for (int i = 0; i < 2 * TL_PER; i++) begin
            drive((i < 8) || (i >= 15 && i < 23), 1'b0, 3'b000);
            obs = {walk, dont_walk, flash, countdown, req_pending, fault};
            n_checks++;
            if (obs !== m_exp) begin
                n_errors++;
                $display("FAIL back_to_back i=%0d: got %b, expected %b", i, obs, m_exp);
            end
            if (walk) n_walk++;
            if (walk && !prev_walk) n_starts++;
            if ((walk || flash) && req_pending) req_in_cycle = 1'b1;
            prev_walk = walk;
        end
        n_checks++;
        if (n_starts != 2 || n_walk != int'(2 * W) || req_in_cycle !== 1'b1) begin
            n_errors++;
            $display("FAIL second_walk: got starts=%0d walk=%0d req=%b, expected 2 %0d 1",
                     n_starts, n_walk, req_in_cycle, 2 * W);
        end
    endtask

    task automatic test_abort();
        logic [8:0] obs;
        logic late_walk = 1'b0;
        for (int i = 0; i < TL_PER; i++) begin
            drive(i < 8, i == 17, 3'b010);
            obs = {walk, dont_walk, flash, countdown, req_pending, fault};
            n_checks++;
            if (obs !== m_exp) begin
                n_errors++;
                $display("FAIL abort i=%0d: got %b, expected %b", i, obs, m_exp);
            end
            if (i == 16) begin
                n_checks++;
                if (walk !== 1'b1) begin
                    n_errors++;
                    $display("FAIL abort_pre: got walk=%b, expected 1", walk);
                end
            end
            if (i == 17) begin
                n_checks++;
                if ({walk, dont_walk, flash, countdown} !== 7'b0100000) begin
                    n_errors++;
                    $display("FAIL abort_safe: got %b, expected 0100000",
                             {walk, dont_walk, flash, countdown});
                end
            end
            if (i >= 17 && (walk || flash || req_pending)) late_walk = 1'b1;
        end
        n_checks++;
        if (late_walk !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_no_requeue: got %b, expected 0", late_walk);
        end
    endtask

    task automatic test_fault();
        logic [8:0] obs;
        int n_walk = 0;
        for (int i = 0; i < TL_PER; i++) begin
            drive(i < 8, (i == 9) || (i == 10), 3'b110);
            obs = {walk, dont_walk, flash, countdown, req_pending, fault};
            n_checks++;
            if (obs !== m_exp) begin
                n_errors++;
                $display("FAIL fault i=%0d: got %b, expected %b", i, obs, m_exp);
            end
            if (i == 9 || i == 10) begin
                n_checks++;
                if ({fault, req_pending, walk, dont_walk} !== 4'b1101) begin
                    n_errors++;
                    $display("FAIL fault_active i=%0d: got %b, expected 1101",
                             i, {fault, req_pending, walk, dont_walk});
                end
            end
            if (i == 11) begin
                n_checks++;
                if (fault !== 1'b0) begin
                    n_errors++;
                    $display("FAIL fault_clear: got %b, expected 0", fault);
                end
            end
            if (walk) n_walk++;
        end
        n_checks++;
        if (n_walk != int'(W)) begin
            n_errors++;
            $display("FAIL fault_then_walk: got %0d, expected %0d", n_walk, W);
        end
    endtask

    task automatic test_mid_reset();
        logic [8:0] obs;
        logic [8:0] rst_vec;
        rst_vec = {1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0};
        for (int i = 0; i < 17; i++) drive(i < 8, 1'b0, 3'b000);
        n_checks++;
        if (walk !== 1'b1) begin
            n_errors++;
            $display("FAIL mid_reset_pre: got walk=%b, expected 1", walk);
        end
        #2 reset = 1'b1;
        #1;
        obs = {walk, dont_walk, flash, countdown, req_pending, fault};
        n_checks++;
        if (obs !== rst_vec || obs !== m_exp) begin
            n_errors++;
            $display("FAIL mid_reset: got %b, expected %b", obs, rst_vec);
        end
        @(negedge clk);
        reset = 1'b0;
        tl_t = 0;
        for (int i = 0; i < TL_PER; i++) begin
            drive(1'b0, 1'b0, 3'b000);
            obs = {walk, dont_walk, flash, countdown, req_pending, fault};
            n_checks++;
            if (obs !== m_exp) begin
                n_errors++;
                $display("FAIL post_reset i=%0d: got %b, expected %b", i, obs, m_exp);
            end
        end
    endtask

    task automatic test_random();
        logic [8:0] obs;
        logic       b = 1'b0;
        logic       ovr;
        logic [2:0] rgy;
        int         hold = 0;
        for (int i = 0; i < 900; i++) begin
            if (hold == 0) begin
                b    = 1'($urandom_range(0, 1));
                hold = int'($urandom_range(1, 12));
            end
            hold--;
            ovr = ($urandom_range(0, 59) == 0);
            rgy = 3'($urandom_range(0, 7));
            drive(b, ovr, rgy);
            obs = {walk, dont_walk, flash, countdown, req_pending, fault};
            n_checks++;
            if (obs !== m_exp) begin
                n_errors++;
                $display("FAIL random i=%0d: got %b, expected %b", i, obs, m_exp);
            end
        end
    endtask

    initial begin
        #1 reset = 1'b1;
        @(negedge clk);
        test_reset();
        test_walk_cycle();
        test_glitch();
        test_back_to_back();
        test_abort();
        test_fault();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ped_crossing_ctrl.md
Name: ped_crossing_ctrl

Overview:
- Downstream consumer of the vehicle traffic-light controller: takes its Red/Green/Yellow outputs plus a raw pedestrian push-button and drives the pedestrian WALK / DON'T-WALK lamps.
- Latches a debounced request and grants WALK only at the start of a vehicle-red phase.
- Follows WALK with a flashing clearance interval and a countdown, then returns to solid DON'T-WALK.
- Forces the safe state whenever the vehicle lights are not exactly one-hot or red ends early.

Parameters:
- DEBOUNCE_CYC, 4, consecutive synchronised-high cycles required to accept a press (1..15)
- WALK_CYC, 6, cycles WALK is lit (1..15)
- CLEAR_CYC, 5, cycles of flashing DON'T-WALK clearance (1..15); WALK_CYC+CLEAR_CYC must not exceed vehicle red length (16)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- veh_red  input  1  vehicle Red lamp from traffic controller
- veh_green  input  1  vehicle Green lamp
- veh_yellow  input  1  vehicle Yellow lamp
- ped_btn  input  1  raw, asynchronous pedestrian button
- walk  output  1  WALK lamp, registered
- dont_walk  output  1  DON'T-WALK lamp, registered
- flash  output  1  high during clearance interval
- countdown  output  4  remaining clearance cycles, 0 otherwise
- req_pending  output  1  accepted request awaiting service
- fault  output  1  vehicle lamp inputs not one-hot this cycle

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset). All outputs registered.
- Reset values: walk=0, dont_walk=1, flash=0, countdown=0, req_pending=0, fault=0, state=IDLE, all counters 0, red_d=0.
- Button path: 2-FF synchroniser then debounce counter. Counter increments while the synced button is 1 (saturating) and clears to 0 when it is 0. btn_db is 1 when count==DEBOUNCE_CYC.
- A rising edge of btn_db sets req_pending on the next edge. Worst-case latency from a steady press is DEBOUNCE_CYC+3 cycles. Holding the button generates no further requests.
- Red-start detect: red_d <= veh_red. red_start = veh_red & ~red_d & lights_ok, where lights_ok means exactly one of the three vehicle inputs is 1.
- FSM states: IDLE, WAIT_RED, WALK, CLEAR.
- IDLE: dont_walk=1. If req_pending goes to WAIT_RED. A press that has been accepted while already in red is still held until the next red_start.
- WAIT_RED: on red_start goes to WALK, clears req_pending, loads the timer with WALK_CYC-1.
- WALK: walk=1, dont_walk=0. Timer decrements each cycle. At timer 0 goes to CLEAR and loads the timer with CLEAR_CYC-1.
- CLEAR: walk=0, flash=1, countdown=timer. dont_walk=1 on the first CLEAR cycle and toggles every cycle after that. At timer 0 goes to IDLE.
- Abort: in WALK or CLEAR, if veh_red=0 or !lights_ok, go to IDLE next edge. Outputs become walk=0, dont_walk=1, flash=0, countdown=0. A request served by the aborted cycle is not re-queued.
- fault = registered !lights_ok, not sticky. While fault=1 the FSM stays in or enters IDLE and red_start is suppressed. req_pending is retained.
- Presses accepted during WALK or CLEAR set req_pending and are served at the next red_start. A press during WAIT_RED has no additional effect.
- If the press edge and red_start occur in the same cycle in IDLE, service waits for the following red.
- Reset asserted mid-WALK or mid-CLEAR immediately forces the reset values.

Optional Feature:
- Macro: PED_CHIRP_EN.
- Defined: adds output chirp (1 bit, reset 0).
  - chirp toggles every cycle in WALK.
  - chirp toggles every 2nd cycle in CLEAR.
  - chirp is 0 otherwise.
- Undefined: the chirp port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package ped_pkg holds:
  - state localparams IDLE=2'b00, WAIT_RED=2'b01, WALK=2'b10, CLEAR=2'b11
  - timer width constant (4)
  - the lights_ok one-hot check as a function
- Sub-module ped_btn_debounce (synchroniser + debounce counter + rising-edge pulse, parameter DEBOUNCE_CYC), instantiated once.

Test Plan:
- Reset held 3 cycles, then released with lights driven by the traffic model -> dont_walk=1, walk=0, req_pending=0, fault=0.
- Press held 8 cycles during green -> req_pending=1 within 7 cycles. At the next red rise: walk=1 for 6 cycles, then flash=1 with countdown 4,3,2,1,0 and dont_walk 1,0,1,0,1, then IDLE with req_pending=0.
- 2-cycle button glitch (below DEBOUNCE_CYC) -> req_pending stays 0.
- Second press during WALK -> req_pending=1 after debounce. The current cycle completes, and the second WALK starts at the following red rise.
- veh_red forced to 0 (veh_green=1) on the 3rd WALK cycle -> next edge walk=0, dont_walk=1, flash=0.
- veh_red=veh_green=1 for 2 cycles -> fault=1 for those 2 cycles and FSM stays in IDLE. With PED_CHIRP_EN defined, chirp toggles each WALK cycle; otherwise the port is absent.
